// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage data-hazard unit. It picks forwarding sources
// from the in-order stages and from the long-latency writeback port, stalls
// IF/ID on RAW, WAW and capacity hazards, and tracks in-flight long-latency
// destinations in a busy-bit scoreboard.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int RIDX_W   = 5,
  parameter int NFWD     = 3,
  parameter int MAX_LONG = 4,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [RIDX_W-1:0]      id_rs1,
  input  logic [RIDX_W-1:0]      id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [RIDX_W-1:0]      id_rd,
  input  logic                   id_rd_w_en,
  input  logic                   id_long,
  input  logic                   id_fire,
  input  logic                   flush,
  input  logic [NFWD-1:0]        stg_rd_w_en,
  input  logic [NFWD*RIDX_W-1:0] stg_rd,
  input  logic [NFWD-1:0]        stg_rdy,
  input  logic                   lwb_valid,
  input  logic [RIDX_W-1:0]      lwb_rd,
  output logic [NFWD-1:0]        rs1_fwd_oh,
  output logic [NFWD-1:0]        rs2_fwd_oh,
  output logic                   rs1_fwd_lwb,
  output logic                   rs2_fwd_lwb,
  output logic                   id_stall,
  output logic [NREG-1:0]        sb_busy,
  output logic                   sb_err,
  output logic [CNT_W-1:0]       stall_cycles
);

  localparam int OCNT_W = $clog2(MAX_LONG + 1);
  localparam logic [OCNT_W-1:0] MAX_CNT = OCNT_W'(MAX_LONG);

  logic [NREG-1:0]   busy_q, busy_d;
  logic [OCNT_W-1:0] count_q, count_d;
  logic              err_q;
  logic [CNT_W-1:0]  stall_q;

  logic [RIDX_W-1:0] src [2];
  logic [1:0]        src_used;
  logic [NFWD-1:0]   fwd_oh [2];
  logic [1:0]        fwd_lwb;
  logic [1:0]        raw_stall;
  logic              waw_stall;
  logic              cap_stall;
  logic              do_set;
  logic              do_clr;

  assign src[0]      = id_rs1;
  assign src[1]      = id_rs2;
  assign src_used[0] = id_rs1_used;
  assign src_used[1] = id_rs2_used;

  // Per source: youngest matching stage wins (and shadows older ones even when
  // not ready); with no stage match, a busy register waits for its lwb beat.
  always_comb begin
    logic            hit;
    logic            win_rdy;
    logic [NFWD-1:0] win_oh;
    hit     = 1'b0;
    win_rdy = 1'b0;
    win_oh  = '0;
    for (int s = 0; s < 2; s++) begin
      fwd_oh[s]    = '0;
      fwd_lwb[s]   = 1'b0;
      raw_stall[s] = 1'b0;
      hit          = 1'b0;
      win_rdy      = 1'b0;
      win_oh       = '0;
      if (id_valid && src_used[s] && src[s] != '0) begin
        for (int i = NFWD - 1; i >= 0; i--) begin
          if (stg_rd_w_en[i] && stg_rd[i*RIDX_W +: RIDX_W] == src[s]) begin
            hit       = 1'b1;
            win_rdy   = stg_rdy[i];
            win_oh    = '0;
            win_oh[i] = 1'b1;
          end
        end
        if (hit) begin
          if (win_rdy) fwd_oh[s] = win_oh;
          else         raw_stall[s] = 1'b1;
        end else if (busy_q[src[s]]) begin
          if (lwb_valid && lwb_rd == src[s]) fwd_lwb[s] = 1'b1;
          else                               raw_stall[s] = 1'b1;
        end
      end
    end
  end

  assign waw_stall = id_rd_w_en && id_rd != '0 && busy_q[id_rd] &&
                     !(lwb_valid && lwb_rd == id_rd);
  assign cap_stall = id_long && count_q == MAX_CNT && !lwb_valid;
  assign id_stall  = id_valid && !flush && (|raw_stall || waw_stall || cap_stall);

  assign do_set = id_fire && id_long && id_rd_w_en && id_rd != '0 && !flush;
  assign do_clr = lwb_valid && busy_q[lwb_rd];

  // Scoreboard next state: clear first so a same-register set wins; the
  // outstanding count moves only when exactly one of set/clear happens.
  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (do_clr) busy_d[lwb_rd] = 1'b0;
    if (do_set) busy_d[id_rd]  = 1'b1;
    if (do_set && !do_clr && count_q != MAX_CNT)
      count_d = count_q + OCNT_W'(1);
    else if (do_clr && !do_set && count_q != '0)
      count_d = count_q - OCNT_W'(1);
  end

  // State registers: scoreboard, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      if (lwb_valid && !busy_q[lwb_rd]) err_q <= 1'b1;
      if (id_stall && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign rs1_fwd_oh   = fwd_oh[0];
  assign rs2_fwd_oh   = fwd_oh[1];
  assign rs1_fwd_lwb  = fwd_lwb[0];
  assign rs2_fwd_lwb  = fwd_lwb[1];
  assign sb_busy      = busy_q;
  assign sb_err       = err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table vectors for forwarding selection, hand-written
// scoreboard sequences, then randomized traffic against a reference model.
module tb_hazard_scoreboard;

  localparam int MAX_LONG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_w_en, id_long, id_fire, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd, lwb_rd;
  logic [2:0]  stg_rd_w_en, stg_rdy;
  logic [14:0] stg_rd;
  logic        lwb_valid;
  logic [2:0]  rs1_fwd_oh, rs2_fwd_oh;
  logic        rs1_fwd_lwb, rs2_fwd_lwb, id_stall, sb_err;
  logic [31:0] sb_busy, stall_cycles;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rd_w_en;
    logic       long_op;
    logic       fire;
    logic       flush;
    logic [2:0] wen;
    logic [14:0] rd_pack;
    logic [2:0] rdy;
    logic       lwb_v;
    logic [4:0] lwb_rd;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      st;
    logic [2:0] e_oh1;
    logic [2:0] e_oh2;
    logic       e_stall;
  } vec_t;

  // Reference model state
  bit     m_busy [32];
  int     m_cnt;
  bit     m_err;
  longint m_stall;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_w_en(id_rd_w_en), .id_long(id_long), .id_fire(id_fire), .flush(flush),
    .stg_rd_w_en(stg_rd_w_en), .stg_rd(stg_rd), .stg_rdy(stg_rdy),
    .lwb_valid(lwb_valid), .lwb_rd(lwb_rd), .rs1_fwd_oh(rs1_fwd_oh),
    .rs2_fwd_oh(rs2_fwd_oh), .rs1_fwd_lwb(rs1_fwd_lwb), .rs2_fwd_lwb(rs2_fwd_lwb),
    .id_stall(id_stall), .sb_busy(sb_busy), .sb_err(sb_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic vec_t mkv(input string n, input int valid, input int wen,
                               input int r0, input int r1, input int r2, input int rdy,
                               input int rs1, input int u1, input int rs2, input int u2,
                               input int e1, input int e2, input int es);
    vec_t v;
    v.name       = n;
    v.st         = idle();
    v.st.valid   = valid[0];
    v.st.wen     = wen[2:0];
    v.st.rd_pack = {r2[4:0], r1[4:0], r0[4:0]};
    v.st.rdy     = rdy[2:0];
    v.st.rs1     = rs1[4:0];
    v.st.u1      = u1[0];
    v.st.rs2     = rs2[4:0];
    v.st.u2      = u2[0];
    v.e_oh1      = e1[2:0];
    v.e_oh2      = e2[2:0];
    v.e_stall    = es[0];
    return v;
  endfunction

  task automatic applyStimulus(input stim_t s);
    id_valid    = s.valid;
    id_rs1      = s.rs1;
    id_rs1_used = s.u1;
    id_rs2      = s.rs2;
    id_rs2_used = s.u2;
    id_rd       = s.rd;
    id_rd_w_en  = s.rd_w_en;
    id_long     = s.long_op;
    id_fire     = s.fire;
    flush       = s.flush;
    stg_rd_w_en = s.wen;
    stg_rd      = s.rd_pack;
    stg_rdy     = s.rdy;
    lwb_valid   = s.lwb_v;
    lwb_rd      = s.lwb_rd;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_comb(input string n, input logic [2:0] e1, input logic [2:0] e2,
                            input logic el1, input logic el2, input logic es);
    checkOutput({n, ".rs1_fwd_oh"}, 64'(rs1_fwd_oh), 64'(e1));
    checkOutput({n, ".rs2_fwd_oh"}, 64'(rs2_fwd_oh), 64'(e2));
    checkOutput({n, ".rs1_fwd_lwb"}, 64'(rs1_fwd_lwb), 64'(el1));
    checkOutput({n, ".rs2_fwd_lwb"}, 64'(rs2_fwd_lwb), 64'(el2));
    checkOutput({n, ".id_stall"}, 64'(id_stall), 64'(es));
  endtask

  task automatic check_state(input string n, input logic [31:0] busy, input logic err,
                             input logic [31:0] scnt);
    checkOutput({n, ".sb_busy"}, 64'(sb_busy), 64'(busy));
    checkOutput({n, ".sb_err"}, 64'(sb_err), 64'(err));
    checkOutput({n, ".stall_cycles"}, 64'(stall_cycles), 64'(scnt));
  endtask

  // Apply one cycle of stimulus, check combinational outputs mid-cycle, then
  // advance to just after the next rising edge.
  task automatic run_cycle(input stim_t s, input string n, input logic [2:0] e1,
                           input logic [2:0] e2, input logic el1, input logic el2,
                           input logic es);
    applyStimulus(s);
    #4;
    check_comb(n, e1, e2, el1, el2, es);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    applyStimulus(idle());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_busy  = '{default: 1'b0};
    m_cnt   = 0;
    m_err   = 1'b0;
    m_stall = 0;
  endtask

  // Reference: per-source forwarding decision from the hazard rules.
  function automatic void model_src(input stim_t s, input logic [4:0] r, input logic used,
                                    output logic [2:0] oh, output logic lwb, output logic st);
    logic [4:0] srd;
    oh  = '0;
    lwb = 1'b0;
    st  = 1'b0;
    if (!(s.valid && used && r != 0)) return;
    for (int i = 0; i < 3; i++) begin
      srd = s.rd_pack[i*5 +: 5];
      if (s.wen[i] && srd == r) begin
        if (s.rdy[i]) oh = 3'(1 << i);
        else          st = 1'b1;
        return;
      end
    end
    if (m_busy[r]) begin
      if (s.lwb_v && s.lwb_rd == r) lwb = 1'b1;
      else                          st  = 1'b1;
    end
  endfunction

  function automatic logic model_stall(input stim_t s, input logic st1, input logic st2);
    logic waw, cap;
    waw = s.rd_w_en && s.rd != 0 && m_busy[s.rd] && !(s.lwb_v && s.lwb_rd == s.rd);
    cap = s.long_op && m_cnt == MAX_LONG && !s.lwb_v;
    return s.valid && !s.flush && (st1 || st2 || waw || cap);
  endfunction

  task automatic model_update(input stim_t s, input logic st);
    logic set, clr;
    set = s.fire && s.long_op && s.rd_w_en && s.rd != 0 && !s.flush;
    clr = s.lwb_v && m_busy[s.lwb_rd];
    if (s.lwb_v && !m_busy[s.lwb_rd]) m_err = 1'b1;
    if (clr) m_busy[s.lwb_rd] = 1'b0;
    if (set) m_busy[s.rd] = 1'b1;
    m_cnt = m_cnt + int'(set) - int'(clr);
    if (st && m_stall < 64'hFFFF_FFFF) m_stall++;
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  vec_t  vecs [12];
  stim_t s;

  initial begin
    vecs[0]  = mkv("ex_fwd",            1, 'b001, 5, 0, 0,  'b111, 5, 1, 0, 0, 'b001, 'b000, 0);
    vecs[1]  = mkv("ex_shadows_mem",    1, 'b011, 5, 5, 0,  'b111, 5, 1, 0, 0, 'b001, 'b000, 0);
    vecs[2]  = mkv("load_in_ex",        1, 'b001, 7, 0, 0,  'b110, 0, 0, 7, 1, 'b000, 'b000, 1);
    vecs[3]  = mkv("load_in_mem",       1, 'b010, 0, 7, 0,  'b111, 0, 0, 7, 1, 'b000, 'b010, 0);
    vecs[4]  = mkv("x0_never",          1, 'b111, 0, 0, 0,  'b000, 0, 1, 0, 1, 'b000, 'b000, 0);
    vecs[5]  = mkv("unready_shadow",    1, 'b011, 3, 3, 0,  'b110, 3, 1, 0, 0, 'b000, 'b000, 1);
    vecs[6]  = mkv("unused_src",        1, 'b001, 4, 0, 0,  'b000, 4, 0, 4, 0, 'b000, 'b000, 0);
    vecs[7]  = mkv("invalid_id",        0, 'b001, 7, 0, 0,  'b000, 7, 1, 7, 1, 'b000, 'b000, 0);
    vecs[8]  = mkv("wb_both",           1, 'b100, 0, 0, 8,  'b111, 8, 1, 8, 1, 'b100, 'b100, 0);
    vecs[9]  = mkv("wen_off_skip",      1, 'b010, 1, 1, 0,  'b111, 1, 1, 0, 0, 'b010, 'b000, 0);
    vecs[10] = mkv("split_srcs",        1, 'b101, 6, 0, 10, 'b111, 10, 1, 6, 1, 'b100, 'b001, 0);
    vecs[11] = mkv("rs2_stall_rs1_fwd", 1, 'b011, 2, 9, 0,  'b010, 9, 1, 2, 1, 'b010, 'b000, 1);

    do_reset();
    #4;
    check_state("reset", 32'h0, 1'b0, 32'd0);
    check_comb("reset_idle", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 12; v++)
      run_cycle(vecs[v].st, vecs[v].name, vecs[v].e_oh1, vecs[v].e_oh2, 1'b0, 1'b0,
                vecs[v].e_stall);

    // Long div to x9, consumer stalls until its writeback is forwarded.
    do_reset();
    s = idle(); s.valid = 1; s.long_op = 1; s.rd_w_en = 1; s.rd = 5'd9; s.fire = 1;
    run_cycle(s, "div_issue", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    check_state("div_busy", 32'h0000_0200, 1'b0, 32'd0);
    s = idle(); s.valid = 1; s.rs1 = 5'd9; s.u1 = 1;
    run_cycle(s, "div_raw_0", 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
    run_cycle(s, "div_raw_1", 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
    s.lwb_v = 1; s.lwb_rd = 5'd9; s.fire = 1;
    run_cycle(s, "div_lwb_fwd", 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    check_state("div_done", 32'h0, 1'b0, 32'd2);

    // Fill to capacity with x1..x4, then probe capacity and WAW stalls.
    for (int r = 1; r <= 4; r++) begin
      s = idle(); s.valid = 1; s.long_op = 1; s.rd_w_en = 1; s.rd = 5'(r); s.fire = 1;
      run_cycle(s, "fill", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    end
    check_state("full", 32'h0000_001E, 1'b0, 32'd2);
    s = idle(); s.valid = 1; s.long_op = 1; s.rd_w_en = 1; s.rd = 5'd5;
    run_cycle(s, "cap_stall", 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
    s.lwb_v = 1; s.lwb_rd = 5'd2; s.fire = 1;
    run_cycle(s, "cap_lwb_pass", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    check_state("cap_swap", 32'h0000_003A, 1'b0, 32'd3);
    s = idle(); s.valid = 1; s.long_op = 1; s.rd_w_en = 1; s.rd = 5'd6;
    run_cycle(s, "cap_still_full", 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
    s = idle(); s.valid = 1; s.rd_w_en = 1; s.rd = 5'd3;
    run_cycle(s, "waw_stall", 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
    s.lwb_v = 1; s.lwb_rd = 5'd3;
    run_cycle(s, "waw_lwb_pass", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    check_state("waw_cleared", 32'h0000_0032, 1'b0, 32'd5);

    // Spurious writeback sets the sticky error without touching the scoreboard.
    s = idle(); s.lwb_v = 1; s.lwb_rd = 5'd12;
    run_cycle(s, "lwb_spurious", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    check_state("err_set", 32'h0000_0032, 1'b1, 32'd5);
    s = idle(); s.valid = 1; s.u1 = 1; s.wen = 3'b111;
    run_cycle(s, "x0_all_stages", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    check_state("err_sticky", 32'h0000_0032, 1'b1, 32'd5);

    // Flush masks a live stall and blocks a long issue.
    s = idle(); s.valid = 1; s.rs1 = 5'd1; s.u1 = 1;
    run_cycle(s, "pre_flush_stall", 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
    s.flush = 1; s.long_op = 1; s.rd_w_en = 1; s.rd = 5'd20; s.fire = 1;
    run_cycle(s, "flush_masks", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    check_state("flush_no_set", 32'h0000_0032, 1'b1, 32'd6);

    do_reset();
    #4;
    check_state("mid_reset", 32'h0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    s = idle(); s.valid = 1; s.rs2 = 5'd7; s.u2 = 1; s.wen = 3'b001;
    s.rd_pack = 15'd7; s.rdy = 3'b000;
    for (int c = 0; c < 10; c++)
      run_cycle(s, "hold_stall", 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
    check_state("stall_count", 32'h0, 1'b0, 32'd10);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] e1, e2;
      logic       l1, l2, st1, st2, est, clears;
      int         bq[$];
      s = idle();
      s.valid   = ($urandom % 8) != 0;
      s.rs1     = 5'($urandom % 8);
      s.u1      = ($urandom % 4) != 0;
      s.rs2     = 5'($urandom % 8);
      s.u2      = ($urandom % 4) != 0;
      s.rd      = 5'($urandom % 8);
      s.rd_w_en = ($urandom % 4) != 0;
      s.long_op = ($urandom % 3) == 0;
      s.flush   = ($urandom % 10) == 0;
      s.wen     = 3'($urandom);
      s.rd_pack = {5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8)};
      s.rdy     = 3'($urandom);
      s.lwb_v   = ($urandom % 3) == 0;
      bq = {};
      for (int r = 1; r < 32; r++) if (m_busy[r]) bq.push_back(r);
      if (bq.size() > 0 && ($urandom % 10) != 0)
        s.lwb_rd = 5'(bq[$urandom_range(0, bq.size() - 1)]);
      else
        s.lwb_rd = 5'($urandom % 8);
      model_src(s, s.rs1, s.u1, e1, l1, st1);
      model_src(s, s.rs2, s.u2, e2, l2, st2);
      est    = model_stall(s, st1, st2);
      clears = s.lwb_v && m_busy[s.lwb_rd];
      s.fire = s.valid && !est && ($urandom % 2) == 1 &&
               !(s.long_op && m_cnt == MAX_LONG && !clears);
      applyStimulus(s);
      #4;
      check_comb("rand", e1, e2, l1, l2, est);
      check_state("rand", model_busy_vec(), m_err, 32'(m_stall));
      model_update(s, est);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
